// File: rtl/unstripe_scheduler.sv
// unstripe_scheduler: per-lane word FIFOs feeding a strict lane0/lane1
// alternating byte serializer (MSB byte first) on an 8-bit valid/ready port.
// Optional starved-lane skip logic is built when UNSTRIPE_SKIP_EN is defined.

// Single-lane word FIFO: registered pointers, count-based full/empty.
module unstripe_fifo #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wdata,
    input  logic        wvalid,
    output logic        wready,
    input  logic        pop,
    output logic [31:0] rdata,
    output logic        empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    logic [DEPTH-1:0][31:0] mem;
    logic [AW-1:0]          wptr;
    logic [AW-1:0]          rptr;
    logic [AW:0]            count;
    logic                   push;
    logic                   rd;

    // Ready depends only on the registered count, so a full FIFO refuses a
    // write even in a cycle where it is being read.
    assign wready = reset & (count != FULL);
    assign empty  = (count == '0);
    assign push   = wvalid & wready;
    assign rd     = pop & ~empty;
    assign rdata  = mem[rptr];

    // Pointer and occupancy tracking; reset empties the FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (rd)   rptr <= rptr + 1'b1;
            case ({push, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset; validity is carried by the count.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end
endmodule

module unstripe_scheduler #(
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] lane0,
    input  logic        valid0,
    output logic        ready0,
    input  logic [31:0] lane1,
    input  logic        valid1,
    output logic        ready1,
    output logic [7:0]  data_out,
    output logic        valid_out,
    input  logic        ready_out,
    output logic        exp_lane,
    output logic        busy,
    output logic        skipped
);
    localparam int NUM_LANES = 2;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    // Configuration sanity check at elaboration time.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
        $error("unstripe_scheduler: DEPTH must be a power of 2 >= 2, TIMEOUT in 1..255");
    end

    logic [NUM_LANES-1:0][31:0] in_data;
    logic [NUM_LANES-1:0]       in_valid;
    logic [NUM_LANES-1:0]       in_ready;
    logic [NUM_LANES-1:0][31:0] rdata;
    logic [NUM_LANES-1:0]       empty;
    logic [NUM_LANES-1:0]       pop;

    assign in_data  = {lane1, lane0};
    assign in_valid = {valid1, valid0};
    assign ready0   = in_ready[0];
    assign ready1   = in_ready[1];

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        unstripe_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk    (clk),
            .reset  (reset),
            .wdata  (in_data[g]),
            .wvalid (in_valid[g]),
            .wready (in_ready[g]),
            .pop    (pop[g]),
            .rdata  (rdata[g]),
            .empty  (empty[g])
        );
    end

    state_t      state, state_nxt;
    logic [31:0] shift_q, shift_nxt;
    logic [1:0]  byte_cnt, cnt_nxt;
    logic        exp_q, exp_nxt;
    logic        oth;

    assign oth = ~exp_q;

`ifdef UNSTRIPE_SKIP_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] starve_q, starve_nxt;
    logic       skip;
`endif

    // State and datapath registers; reset discards any partial word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            shift_q  <= '0;
            byte_cnt <= '0;
            exp_q    <= 1'b0;
`ifdef UNSTRIPE_SKIP_EN
            starve_q <= '0;
`endif
        end else begin
            state    <= state_nxt;
            shift_q  <= shift_nxt;
            byte_cnt <= cnt_nxt;
            exp_q    <= exp_nxt;
`ifdef UNSTRIPE_SKIP_EN
            starve_q <= starve_nxt;
`endif
        end
    end

    // Next state: load only from the expected lane; at end of word switch
    // lanes and chain straight into the next word when one is waiting.
    always_comb begin
        state_nxt = state;
        shift_nxt = shift_q;
        cnt_nxt   = byte_cnt;
        exp_nxt   = exp_q;
        pop       = '0;
`ifdef UNSTRIPE_SKIP_EN
        starve_nxt = '0;
        skip       = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!empty[exp_q]) begin
                    pop[exp_q] = 1'b1;
                    shift_nxt  = rdata[exp_q];
                    cnt_nxt    = 2'd0;
                    state_nxt  = SHIFT;
                end
`ifdef UNSTRIPE_SKIP_EN
                else if (!empty[oth]) begin
                    // Other lane has data but ours is starved: give up on
                    // ours after TIMEOUT such cycles.
                    if (starve_q == TO_LAST) begin
                        exp_nxt = oth;
                        skip    = 1'b1;
                    end else begin
                        starve_nxt = starve_q + 8'd1;
                    end
                end
`endif
            end
            SHIFT: begin
                if (ready_out) begin
                    if (byte_cnt != 2'd3) begin
                        shift_nxt = {shift_q[23:0], 8'h00};
                        cnt_nxt   = byte_cnt + 2'd1;
                    end else begin
                        exp_nxt = oth;
                        if (!empty[oth]) begin
                            pop[oth]  = 1'b1;
                            shift_nxt = rdata[oth];
                            cnt_nxt   = 2'd0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        busy      = (state == SHIFT);
        valid_out = busy;
        data_out  = busy ? shift_q[31:24] : 8'h00;
        exp_lane  = exp_q;
    end

`ifdef UNSTRIPE_SKIP_EN
    assign skipped = skip;
`else
    assign skipped = 1'b0;
`endif
endmodule

// File: tb/tb_unstripe_scheduler.sv
// Directed bench for unstripe_scheduler (DEPTH=2, TIMEOUT=8).
module tb_unstripe_scheduler;
    logic        clk;
    logic        reset;
    logic [31:0] lane0, lane1;
    logic        valid0, valid1, ready0, ready1;
    logic [7:0]  data_out;
    logic        valid_out, ready_out, exp_lane, busy, skipped;

    int errors = 0;
    int checks = 0;

    unstripe_scheduler #(.DEPTH(2), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .lane0(lane0), .valid0(valid0), .ready0(ready0),
        .lane1(lane1), .valid1(valid1), .ready1(ready1),
        .data_out(data_out), .valid_out(valid_out), .ready_out(ready_out),
        .exp_lane(exp_lane), .busy(busy), .skipped(skipped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_a;
        logic        v0;
        logic [31:0] l0;
        logic        v1;
        logic [31:0] l1;
        logic        ro;
        logic        e_vo;
        logic [7:0]  e_d;
        logic        e_exp;
        logic        e_r0;
        logic        e_r1;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic ra, logic v0, logic [31:0] l0, logic v1, logic [31:0] l1,
                                logic ro, logic evo, logic [7:0] ed, logic eexp, logic er0, logic er1);
        vec_t v;
        v.rst_a = ra; v.v0 = v0; v.l0 = l0; v.v1 = v1; v.l1 = l1; v.ro = ro;
        v.e_vo = evo; v.e_d = ed; v.e_exp = eexp; v.e_r0 = er0; v.e_r1 = er1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [31:0] l0, input logic v1, input logic [31:0] l1,
                         input logic ro);
        valid0 = v0; lane0 = l0; valid1 = v1; lane1 = l1; ready_out = ro;
    endtask

    // Repeat one row n times
    task automatic add(input vec_t v, input int n);
        for (int i = 0; i < n; i++) tv.push_back(v);
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        #2;
        chk("rst_valid_out", valid_out, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_ready0", ready0, 0);
        chk("rst_ready1", ready1, 0);
        chk("rst_exp_lane", exp_lane, 0);
        chk("rst_busy", busy, 0);
        chk("rst_skipped", skipped, 0);
        tick();

        // Test 1: single lane0 word, then IDLE expecting lane1
        add(mk(0, 1, 32'hAAAAAAAA, 0, 0, 1, 0, 8'h00, 0, 1, 1), 1);
        add(mk(0, 0, 0, 0, 0, 1, 1, 8'hAA, 0, 1, 1), 4);
        add(mk(0, 0, 0, 0, 0, 1, 0, 8'h00, 1, 1, 1), 1);
        add(mk(1, 0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0), 1);
        // Test 2: both lanes same edge, 8 bytes back to back
        add(mk(0, 1, 32'hBBBBBBBB, 1, 32'hCCCCCCCC, 1, 0, 8'h00, 0, 1, 1), 1);
        add(mk(0, 0, 0, 0, 0, 1, 1, 8'hBB, 0, 1, 1), 4);
        add(mk(0, 0, 0, 0, 0, 1, 1, 8'hCC, 1, 1, 1), 4);
        add(mk(0, 0, 0, 0, 0, 1, 0, 8'h00, 0, 1, 1), 1);
        // Test 3: downstream stall holds the first byte
        add(mk(0, 1, 32'h01234567, 0, 0, 1, 0, 8'h00, 0, 1, 1), 1);
        add(mk(0, 0, 0, 0, 0, 1, 1, 8'h01, 0, 1, 1), 1);
        add(mk(0, 0, 0, 0, 0, 0, 1, 8'h01, 0, 1, 1), 3);
        add(mk(0, 0, 0, 0, 0, 1, 1, 8'h23, 0, 1, 1), 1);
        add(mk(0, 0, 0, 0, 0, 1, 1, 8'h45, 0, 1, 1), 1);
        add(mk(0, 0, 0, 0, 0, 1, 1, 8'h67, 0, 1, 1), 1);
        add(mk(0, 0, 0, 0, 0, 1, 0, 8'h00, 1, 1, 1), 1);
        add(mk(1, 0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0), 1);
        // Test 4: lane1 overfill while lane0 is expected, strict alternation
        add(mk(0, 0, 0, 1, 32'h11111111, 1, 0, 8'h00, 0, 1, 1), 1);
        add(mk(0, 0, 0, 1, 32'h22222222, 1, 0, 8'h00, 0, 1, 0), 1);
        add(mk(0, 0, 0, 1, 32'h33333333, 1, 0, 8'h00, 0, 1, 0), 1);
        add(mk(0, 0, 0, 0, 0, 1, 0, 8'h00, 0, 1, 0), 1);
        add(mk(0, 1, 32'h44444444, 0, 0, 1, 0, 8'h00, 0, 1, 0), 1);
        add(mk(0, 0, 0, 0, 0, 1, 1, 8'h44, 0, 1, 0), 4);
        add(mk(0, 0, 0, 0, 0, 1, 1, 8'h11, 1, 1, 1), 4);
        add(mk(0, 0, 0, 0, 0, 1, 0, 8'h00, 0, 1, 1), 1);
        add(mk(0, 1, 32'h55555555, 0, 0, 1, 0, 8'h00, 0, 1, 1), 1);
        add(mk(0, 0, 0, 0, 0, 1, 1, 8'h55, 0, 1, 1), 4);
        add(mk(0, 0, 0, 0, 0, 1, 1, 8'h22, 1, 1, 1), 4);
        add(mk(0, 0, 0, 0, 0, 1, 0, 8'h00, 0, 1, 1), 1);

        foreach (tv[i]) begin
            reset = ~tv[i].rst_a;
            drive(tv[i].v0, tv[i].l0, tv[i].v1, tv[i].l1, tv[i].ro);
            tick();
            chk($sformatf("row%0d_valid_out", i), valid_out, tv[i].e_vo);
            if (tv[i].e_vo) chk($sformatf("row%0d_data_out", i), data_out, tv[i].e_d);
            chk($sformatf("row%0d_exp_lane", i), exp_lane, tv[i].e_exp);
            chk($sformatf("row%0d_ready0", i), ready0, tv[i].e_r0);
            chk($sformatf("row%0d_ready1", i), ready1, tv[i].e_r1);
            chk($sformatf("row%0d_busy", i), busy, tv[i].e_vo);
            chk($sformatf("row%0d_skipped", i), skipped, 0);
        end
        reset = 1'b1;

        // Test 5: reset in the middle of a word with both FIFOs holding data
        drive(1, 32'hDDDDDDDD, 1, 32'h99999999, 1);
        tick();
        drive(1, 32'hEEEEEEEE, 0, 0, 1);
        tick();
        chk("t5_byte1", data_out, 8'hDD);
        drive(0, 0, 0, 0, 1);
        tick();
        chk("t5_byte2", data_out, 8'hDD);
        chk("t5_byte2_valid", valid_out, 1);
        reset = 1'b0;
        #1;
        chk("t5_rst_valid_out", valid_out, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_exp_lane", exp_lane, 0);
        chk("t5_rst_ready0", ready0, 0);
        chk("t5_rst_ready1", ready1, 0);
        tick();
        reset = 1'b1;
        #1;
        chk("t5_rel_ready0", ready0, 1);
        chk("t5_rel_ready1", ready1, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("t5_idle%0d_valid_out", k), valid_out, 0);
        end
        drive(1, 32'h0A0B0C0D, 0, 0, 1);
        tick();
        chk("t5_new_write_valid_out", valid_out, 0);
        drive(0, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] w;
            w = 32'h0A0B0C0D;
            tick();
            chk($sformatf("t5_new_byte%0d", k), data_out, w[31-8*k -: 8]);
            chk($sformatf("t5_new_valid%0d", k), valid_out, 1);
        end
        tick();
        chk("t5_end_valid_out", valid_out, 0);
        chk("t5_end_exp_lane", exp_lane, 1);

        // Test 6: only the unexpected lane has data
        reset = 1'b0;
        tick();
        reset = 1'b1;
        drive(0, 0, 1, 32'hFFFFFFFF, 1);
        tick();
        drive(0, 0, 0, 0, 1);
`ifdef UNSTRIPE_SKIP_EN
        for (int k = 0; k < 8; k++) begin
            logic want;
            want = (k == 7);
            chk($sformatf("t6_starve%0d_skipped", k), skipped, want);
            chk($sformatf("t6_starve%0d_valid_out", k), valid_out, 0);
            chk($sformatf("t6_starve%0d_exp_lane", k), exp_lane, 0);
            tick();
        end
        chk("t6_after_skip_exp_lane", exp_lane, 1);
        chk("t6_after_skip_skipped", skipped, 0);
        chk("t6_after_skip_valid_out", valid_out, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t6_byte%0d", k), data_out, 8'hFF);
            chk($sformatf("t6_valid%0d", k), valid_out, 1);
        end
        tick();
        chk("t6_end_valid_out", valid_out, 0);
        chk("t6_end_exp_lane", exp_lane, 0);
`else
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("t6_wait%0d_skipped", k), skipped, 0);
            chk($sformatf("t6_wait%0d_valid_out", k), valid_out, 0);
            chk($sformatf("t6_wait%0d_exp_lane", k), exp_lane, 0);
            tick();
        end
        chk("t6_ready1_held", ready1, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
